// File: rtl/rr_wormhole_arbiter.sv
// rtl/rr_wormhole_arbiter.sv - round-robin wormhole output arbiter with credit flow control
module rr_wormhole_arbiter #(
    parameter int N_INPUTS   = 5,
    parameter int DATA_WIDTH = 8,
    parameter int DN_CREDITS = 3,
    parameter int CNT_W      = $clog2(DN_CREDITS + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_INPUTS-1:0]            empty_i,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] data_i,
    output logic [N_INPUTS-1:0]            rd_en_o,
    input  logic                           credit_i,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic                           valid_o,
    output logic [N_INPUTS-1:0]            grant_o,
    output logic                           busy_o
);

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]     credits_q, credits_d;
    logic                 pending_q, pending_d;
    logic                 tail_seen_q, tail_seen_d;

    logic [DATA_WIDTH-1:0] flit [N_INPUTS];
    logic [DATA_WIDTH-1:0] cur_flit;
    logic                  found;
    logic [IDX_W-1:0]      pick;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W:0]        sum;
    logic                  can_read;
    logic                  tail_now;
    logic                  rd_fire;
    logic                  rd_go;
    logic [IDX_W-1:0]      rd_idx;

    always_comb begin
        for (int k = 0; k < N_INPUTS; k++) begin
            flit[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign cur_flit = flit[grant_q];
    assign can_read = (credits_q != '0);

    // Cyclic search for the first non-empty FIFO at or after rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_INPUTS)) begin
                sum = sum - (IDX_W+1)'(N_INPUTS);
            end
            cand = sum[IDX_W-1:0];
            if (!found && !empty_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        pending_d   = pending_q;
        tail_seen_d = tail_seen_q;
        rd_fire     = 1'b0;
        rd_idx      = grant_q;
        tail_now    = 1'b0;
        valid_o     = 1'b0;
        data_o      = '0;
        busy_o      = 1'b0;
        grant_o     = '0;

        case (state_q)
            IDLE: begin
                if (found && can_read) begin
                    rd_fire     = 1'b1;
                    rd_idx      = pick;
                    state_d     = ACTIVE;
                    grant_d     = pick;
                    pending_d   = 1'b1;
                    tail_seen_d = 1'b0;
                end
            end
            ACTIVE: begin
                busy_o = 1'b1;
                for (int k = 0; k < N_INPUTS; k++) begin
                    grant_o[k] = (grant_q == IDX_W'(k));
                end
                valid_o   = pending_q;
                data_o    = pending_q ? cur_flit : '0;
                tail_now  = pending_q ? cur_flit[DATA_WIDTH-2] : tail_seen_q;
                rd_fire   = !empty_i[grant_q] && can_read && !tail_now;
                pending_d = rd_fire;
                if (pending_q) begin
                    tail_seen_d = tail_now;
                end
                if (pending_q && tail_now) begin
                    state_d     = IDLE;
                    rr_ptr_d    = (grant_q == IDX_W'(N_INPUTS - 1)) ? '0 : grant_q + 1'b1;
                    grant_d     = '0;
                    tail_seen_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A FIFO pop during reset would lose the flit, so reads are held off until release.
    assign rd_go = rd_fire && rst_ni;

    always_comb begin
        for (int k = 0; k < N_INPUTS; k++) begin
            rd_en_o[k] = rd_go && (rd_idx == IDX_W'(k));
        end
    end

    always_comb begin
        credits_d = credits_q;
        if (rd_go && !credit_i) begin
            credits_d = credits_q - 1'b1;
        end else if (!rd_go && credit_i && (credits_q != CNT_W'(DN_CREDITS))) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            credits_q   <= CNT_W'(DN_CREDITS);
            pending_q   <= 1'b0;
            tail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            credits_q   <= credits_d;
            pending_q   <= pending_d;
            tail_seen_q <= tail_seen_d;
        end
    end

endmodule
